// File: rtl/mem_tile_sram_ctrl.sv
// mem_tile_sram_ctrl: OBI subordinate to word-wide SRAM with a credit-checked response FIFO.
// Define MEM_TILE_SRAM_CTRL_ADDR_CHECK_EN to flag out-of-range addresses with err_o.
module mem_tile_sram_ctrl #(
  parameter int unsigned AddrWidth    = 48,
  parameter int unsigned DataWidth    = 512,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned MemSize      = 32'h0010_0000,
  parameter int unsigned SramLatency  = 1,
  parameter int unsigned RspFifoDepth = 2,
  localparam int unsigned BeWidth     = DataWidth / 8,
  localparam int unsigned OffW        = $clog2(BeWidth),
  localparam int unsigned MemW        = $clog2(MemSize),
  localparam int unsigned WordAw      = MemW - OffW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 we_i,
  input  logic [BeWidth-1:0]   be_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [IdWidth-1:0]   aid_i,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic [IdWidth-1:0]   rid_o,
  output logic                 err_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [WordAw-1:0]    sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntW = $clog2(RspFifoDepth + 1);
  localparam int unsigned PtrW =
    (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
  localparam logic [CntW-1:0] Depth = CntW'(RspFifoDepth);

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic               we;
    logic               err;
  } tag_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic                 err;
    logic [DataWidth-1:0] data;
  } rsp_t;

  logic            active_q;
  logic [CntW-1:0] cnt_q;
  logic            acc_err;
  logic            accept;
  logic            pop;
  logic            unused_addr;

  logic [SramLatency-1:0] vld_q;
  tag_t                   tag_q [SramLatency];
  tag_t                   ex_tag;
  logic                   push;
  rsp_t                   push_rsp;

  rsp_t            mem_q [RspFifoDepth];
  logic [PtrW-1:0] rptr_q;
  logic [PtrW-1:0] wptr_q;
  logic [CntW-1:0] occ_q;
  logic            empty;
  logic            store;
  logic            deq;
  rsp_t            head;

  function automatic logic [PtrW-1:0] ptr_inc(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(RspFifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef MEM_TILE_SRAM_CTRL_ADDR_CHECK_EN
  assign acc_err     = |addr_i[AddrWidth-1:MemW];
  assign unused_addr = ^addr_i[OffW-1:0];
`else
  assign acc_err     = 1'b0;
  assign unused_addr = ^{addr_i[AddrWidth-1:MemW],
                         addr_i[OffW-1:0]};
`endif

  // Grant is held off for one cycle after reset release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) active_q <= 1'b0;
    else         active_q <= 1'b1;
  end

  assign gnt_o  = req_i & active_q & (cnt_q < Depth);
  assign accept = req_i & gnt_o;

  assign sram_req_o   = accept & ~acc_err;
  assign sram_we_o    = sram_req_o & we_i;
  assign sram_addr_o  = addr_i[OffW +: WordAw];
  assign sram_wdata_o = wdata_i;
  assign sram_be_o    = be_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < SramLatency; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      tag_q[0] <= '{id: aid_i, we: we_i, err: acc_err};
      for (int i = 1; i < SramLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign ex_tag = tag_q[SramLatency-1];
  assign push   = vld_q[SramLatency-1];

  always_comb begin
    push_rsp      = '0;
    push_rsp.id   = ex_tag.id;
    push_rsp.err  = ex_tag.err;
    push_rsp.data = (ex_tag.we | ex_tag.err) ? '0 : sram_rdata_i;
  end

  // Empty FIFO falls through so read latency equals SramLatency
  assign empty = (occ_q == '0);
  assign store = push & ~(empty & pop);
  assign deq   = pop & ~empty;

  always_comb begin
    head = '0;
    if (!empty)    head = mem_q[rptr_q];
    else if (push) head = push_rsp;
  end

  assign rvalid_o = ~empty | push;
  assign pop      = rvalid_o & rready_i;
  assign rdata_o  = head.data;
  assign rid_o    = head.id;
  assign err_o    = head.err;

  always_ff @(posedge clk_i) begin
    if (store) mem_q[wptr_q] <= push_rsp;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (store) wptr_q <= ptr_inc(wptr_q);
      if (deq)   rptr_q <= ptr_inc(rptr_q);
      occ_q <= occ_q + CntW'(store) - CntW'(deq);
    end
  end

  // Credits cover both in-flight tags and queued responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_q + CntW'(accept) - CntW'(pop);
  end

endmodule

// File: tb/tb_mem_tile_sram_ctrl.sv
// tb_mem_tile_sram_ctrl: directed bench for mem_tile_sram_ctrl.
// Second instance runs SramLatency=2, RspFifoDepth=3 for streaming.
module tb_mem_tile_sram_ctrl;
  localparam int DW = 512;
  localparam int AW = 48;
  localparam int IW = 4;
  localparam int BW = DW / 8;
  localparam int MS = 32'h0010_0000;
  localparam int WA = 14;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic          req0, we0, rready0, gnt0, rvalid0, err0, sreq0, swe0;
  logic [AW-1:0] addr0;
  logic [BW-1:0] be0, sbe0;
  logic [DW-1:0] wdata0, rdata0, swdata0, srdata0;
  logic [IW-1:0] aid0, rid0;
  logic [WA-1:0] saddr0;

  logic          req1, we1, rready1, gnt1, rvalid1, err1, sreq1, swe1;
  logic [AW-1:0] addr1;
  logic [BW-1:0] be1, sbe1;
  logic [DW-1:0] wdata1, rdata1, swdata1, srdata1;
  logic [IW-1:0] aid1, rid1;
  logic [WA-1:0] saddr1;

  mem_tile_sram_ctrl dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req0), .gnt_o(gnt0), .addr_i(addr0),
    .we_i(we0), .be_i(be0), .wdata_i(wdata0), .aid_i(aid0),
    .rvalid_o(rvalid0), .rready_i(rready0), .rdata_o(rdata0),
    .rid_o(rid0), .err_o(err0),
    .sram_req_o(sreq0), .sram_we_o(swe0), .sram_addr_o(saddr0),
    .sram_wdata_o(swdata0), .sram_be_o(sbe0),
    .sram_rdata_i(srdata0)
  );

  mem_tile_sram_ctrl #(.SramLatency(2), .RspFifoDepth(3)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req1), .gnt_o(gnt1), .addr_i(addr1),
    .we_i(we1), .be_i(be1), .wdata_i(wdata1), .aid_i(aid1),
    .rvalid_o(rvalid1), .rready_i(rready1), .rdata_o(rdata1),
    .rid_o(rid1), .err_o(err1),
    .sram_req_o(sreq1), .sram_we_o(swe1), .sram_addr_o(saddr1),
    .sram_wdata_o(swdata1), .sram_be_o(sbe1),
    .sram_rdata_i(srdata1)
  );

  function automatic logic [DW-1:0] pat(input logic [WA-1:0] a);
    return {16{16'hA5A5, 2'b00, a}};
  endfunction

  // Latency-1 SRAM: unwritten words return a per-address pattern
  logic [DW-1:0] mem0 [16];
  logic [15:0]   wr0 = '0;
  always @(posedge clk) begin
    if (sreq0 && swe0) begin
      for (int b = 0; b < BW; b++)
        if (sbe0[b]) mem0[saddr0[3:0]][b*8 +: 8] <= swdata0[b*8 +: 8];
      wr0[saddr0[3:0]] <= 1'b1;
    end
    if (sreq0 && !swe0)
      srdata0 <= wr0[saddr0[3:0]] ? mem0[saddr0[3:0]] : pat(saddr0);
  end

  // Latency-2 SRAM: returns the word address as data
  logic [DW-1:0] p1a;
  always @(posedge clk) begin
    p1a     <= DW'(saddr1);
    srdata1 <= p1a;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = '0; aid0 = 4'h5;
    be0 = '1; wdata0 = '1; rready0 = 1'b1;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; aid1 = '0;
    be1 = '1; wdata1 = '0; rready1 = 1'b1;
    #3;
    tests_run++;
    if (gnt0 !== 1'b0) begin tests_failed++;
      $display("FAIL rst_gnt got %0h want 0", gnt0); end
    tests_run++;
    if ({rvalid0, err0, sreq0, swe0} !== 4'b0) begin tests_failed++;
      $display("FAIL rst_ctl got %b want 0000", {rvalid0, err0, sreq0, swe0}); end
    tests_run++;
    if (rid0 !== '0 || rdata0 !== '0) begin tests_failed++;
      $display("FAIL rst_payload got rid %0h rdata %0h want 0", rid0, rdata0); end
    req0 = 1'b0; we0 = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
  endtask

  task automatic test_read();
    req0 = 1'b1; addr0 = 48'h40; aid0 = 4'd3; we0 = 1'b0; rready0 = 1'b1;
    #3;
    tests_run++;
    if (gnt0 !== 1'b1 || sreq0 !== 1'b1 || swe0 !== 1'b0) begin tests_failed++;
      $display("FAIL rd_gnt got gnt %b req %b we %b want 1 1 0", gnt0, sreq0, swe0); end
    tests_run++;
    if (saddr0 !== 14'd1) begin tests_failed++;
      $display("FAIL rd_addr got %0h want 1", saddr0); end
    tests_run++;
    if (rvalid0 !== 1'b0) begin tests_failed++;
      $display("FAIL rd_early got %b want 0", rvalid0); end
    cyc();
    req0 = 1'b0;
    #3;
    tests_run++;
    if (rvalid0 !== 1'b1 || rid0 !== 4'd3 || err0 !== 1'b0) begin tests_failed++;
      $display("FAIL rd_rsp got v %b rid %0h err %b want 1 3 0", rvalid0, rid0, err0); end
    tests_run++;
    if (rdata0 !== pat(14'd1)) begin tests_failed++;
      $display("FAIL rd_data got %0h want %0h", rdata0, pat(14'd1)); end
    cyc();
    #3;
    tests_run++;
    if (rvalid0 !== 1'b0) begin tests_failed++;
      $display("FAIL rd_after got %b want 0", rvalid0); end
    cyc();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] w;
    w = {16{32'h0BAD_F00D}};
    w[7:0] = 8'h5A;
    w[DW-1 -: 8] = 8'hC3;
    req0 = 1'b1; addr0 = 48'h80; aid0 = 4'd5; we0 = 1'b1;
    be0 = '1; wdata0 = w; rready0 = 1'b1;
    #3;
    tests_run++;
    if (gnt0 !== 1'b1 || sreq0 !== 1'b1 || swe0 !== 1'b1) begin tests_failed++;
      $display("FAIL wr_gnt got gnt %b req %b we %b want 1 1 1", gnt0, sreq0, swe0); end
    tests_run++;
    if (swdata0 !== w || sbe0 !== {BW{1'b1}} || saddr0 !== 14'd2) begin tests_failed++;
      $display("FAIL wr_pass got addr %0h wdata %0h", saddr0, swdata0); end
    cyc();
    req0 = 1'b0; we0 = 1'b0;
    #3;
    tests_run++;
    if (rvalid0 !== 1'b1 || rid0 !== 4'd5 || err0 !== 1'b0 || rdata0 !== '0) begin
      tests_failed++;
      $display("FAIL wr_rsp got v %b rid %0h err %b rdata %0h want 1 5 0 0",
               rvalid0, rid0, err0, rdata0); end
    cyc();
    req0 = 1'b1; aid0 = 4'd6;
    #3;
    tests_run++;
    if (gnt0 !== 1'b1 || swe0 !== 1'b0) begin tests_failed++;
      $display("FAIL wr_rd_gnt got gnt %b we %b want 1 0", gnt0, swe0); end
    cyc();
    req0 = 1'b0;
    #3;
    tests_run++;
    if (rvalid0 !== 1'b1 || rid0 !== 4'd6 || rdata0 !== w) begin tests_failed++;
      $display("FAIL wr_rd_rsp got v %b rid %0h rdata %0h want 1 6 %0h",
               rvalid0, rid0, rdata0, w); end
    cyc();
  endtask

  task automatic test_backpressure();
    bit rq [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    int ai [9] = '{0, 1, 2, 2, 2, 2, 3, 0, 0};
    bit rr [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    bit eg [9] = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
    bit ev [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int er [9] = '{0, 0, 0, 0, 0, 1, 2, 3, 0};
    int g = 0;
    addr0 = 48'h0; we0 = 1'b0;
    for (int c = 0; c < 9; c++) begin
      req0 = rq[c]; aid0 = IW'(ai[c]); rready0 = rr[c];
      #3;
      if (c < 4 && gnt0 === 1'b1) g++;
      tests_run++;
      if (gnt0 !== eg[c]) begin tests_failed++;
        $display("FAIL bp_gnt c%0d got %b want %b", c, gnt0, eg[c]); end
      tests_run++;
      if (rvalid0 !== ev[c]) begin tests_failed++;
        $display("FAIL bp_rvalid c%0d got %b want %b", c, rvalid0, ev[c]); end
      if (ev[c]) begin
        tests_run++;
        if (rid0 !== IW'(er[c]) || rdata0 !== pat(14'd0)) begin tests_failed++;
          $display("FAIL bp_rid c%0d got %0h want %0h", c, rid0, er[c]); end
      end
      if (c == 2) begin
        tests_run++;
        if (sreq0 !== 1'b0) begin tests_failed++;
          $display("FAIL bp_sreq got %b want 0", sreq0); end
      end
      cyc();
    end
    tests_run++;
    if (g != 2) begin tests_failed++;
      $display("FAIL bp_grants got %0d want 2", g); end
  endtask

  task automatic test_streaming();
    for (int c = 0; c < 19; c++) begin
      req1 = (c < 16); addr1 = AW'(c * 64); aid1 = IW'(c);
      we1 = 1'b0; rready1 = 1'b1;
      #3;
      tests_run++;
      if (gnt1 !== (c < 16)) begin tests_failed++;
        $display("FAIL st_gnt c%0d got %b want %b", c, gnt1, (c < 16)); end
      if (c >= 2 && c < 18) begin
        tests_run++;
        if (rvalid1 !== 1'b1 || rid1 !== IW'(c - 2) || rdata1 !== DW'(c - 2)) begin
          tests_failed++;
          $display("FAIL st_rsp c%0d got v %b rid %0h rdata %0h want 1 %0h %0h",
                   c, rvalid1, rid1, rdata1, c - 2, c - 2); end
      end else begin
        tests_run++;
        if (rvalid1 !== 1'b0) begin tests_failed++;
          $display("FAIL st_idle c%0d got %b want 0", c, rvalid1); end
      end
      cyc();
    end
    req1 = 1'b0;
  endtask

  task automatic test_reset_midop();
    addr0 = 48'h0; we0 = 1'b0; rready0 = 1'b0;
    req0 = 1'b1; aid0 = 4'd1;
    cyc();
    aid0 = 4'd2;
    cyc();
    tests_run++;
    if (rvalid0 !== 1'b1) begin tests_failed++;
      $display("FAIL rm_pending got %b want 1", rvalid0); end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({gnt0, rvalid0, err0, sreq0, swe0} !== 5'b0) begin tests_failed++;
      $display("FAIL rm_ctl got %b want 00000", {gnt0, rvalid0, err0, sreq0, swe0}); end
    tests_run++;
    if (rid0 !== '0 || rdata0 !== '0) begin tests_failed++;
      $display("FAIL rm_payload got rid %0h rdata %0h want 0", rid0, rdata0); end
    req0 = 1'b0; rready0 = 1'b1;
    cyc(); cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #3;
      tests_run++;
      if (rvalid0 !== 1'b0) begin tests_failed++;
        $display("FAIL rm_stale c%0d got %b want 0", c, rvalid0); end
      cyc();
    end
    req0 = 1'b1; aid0 = 4'd9;
    #3;
    tests_run++;
    if (gnt0 !== 1'b1) begin tests_failed++;
      $display("FAIL rm_regnt got %b want 1", gnt0); end
    cyc();
    req0 = 1'b0;
    #3;
    tests_run++;
    if (rvalid0 !== 1'b1 || rid0 !== 4'd9) begin tests_failed++;
      $display("FAIL rm_rsp got v %b rid %0h want 1 9", rvalid0, rid0); end
    cyc();
  endtask

  task automatic test_addr_range();
    req0 = 1'b1; addr0 = AW'(MS); aid0 = 4'd7; we0 = 1'b0; rready0 = 1'b1;
    #3;
    tests_run++;
    if (gnt0 !== 1'b1) begin tests_failed++;
      $display("FAIL ar_gnt got %b want 1", gnt0); end
`ifdef MEM_TILE_SRAM_CTRL_ADDR_CHECK_EN
    tests_run++;
    if (sreq0 !== 1'b0) begin tests_failed++;
      $display("FAIL ar_sreq got %b want 0", sreq0); end
    cyc();
    req0 = 1'b0;
    #3;
    tests_run++;
    if (rvalid0 !== 1'b1 || err0 !== 1'b1 || rdata0 !== '0 || rid0 !== 4'd7) begin
      tests_failed++;
      $display("FAIL ar_rsp got v %b err %b rid %0h rdata %0h want 1 1 7 0",
               rvalid0, err0, rid0, rdata0); end
`else
    tests_run++;
    if (sreq0 !== 1'b1 || saddr0 !== '0) begin tests_failed++;
      $display("FAIL ar_alias got req %b addr %0h want 1 0", sreq0, saddr0); end
    cyc();
    req0 = 1'b0;
    #3;
    tests_run++;
    if (rvalid0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== pat(14'd0) || rid0 !== 4'd7) begin
      tests_failed++;
      $display("FAIL ar_rsp got v %b err %b rid %0h rdata %0h want 1 0 7 %0h",
               rvalid0, err0, rid0, rdata0, pat(14'd0)); end
`endif
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_backpressure();
    test_streaming();
    test_reset_midop();
    test_addr_range();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
